rv32i_multicycle: RTL and testbench
===================================

// Module: rv32i_multicycle
// PURPOSE
//  Multi-cycle RV32I core: next generation of our single-cycle RV32I, same ISA subset and debug taps.
//  Fetch and data access go through one external word-wide memory port with a req/ready handshake, so wait states are allowed.
//  Adds an RV32E option, configurable reset/trap vectors, trap on illegal/misaligned, and a retired-instruction counter.
// PARAMETERS
//  RESET_PC   32'h0000_0000  pc value loaded on reset
//  TRAP_PC    32'h0000_0000  pc loaded on ECALL/EBREAK/illegal/misaligned
//  NREGS      32             architectural registers; 32 (RV32I) or 16 (RV32E)
// PORTS
//  clock        in   1   system clock, all state on posedge
//  reset_n      in   1   asynchronous active-low reset
//  mem_req      out  1   memory request valid
//  mem_we       out  1   1 = write (store), 0 = read (fetch/load)
//  mem_addr     out  32  word-aligned byte address ({addr[31:2],2'b00})
//  mem_wdata    out  32  store data, lane-shifted
//  mem_wstrb    out  4   byte enables for writes; 4'b0000 on reads
//  mem_rdata    in   32  read data, valid in the cycle mem_ready=1
//  mem_ready    in   1   transfer completes on posedge where mem_req&mem_ready
//  pc_out       out  32  current pc (debug)
//  op_out       out  32  instruction register (debug)
//  alu_out      out  32  ALU result register (debug)
//  state_out    out  2   FSM state encoding (debug)
//  trap_out     out  1   one-cycle pulse when a trap redirects pc
//  instret_out  out  32  retired instruction count, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=FETCH, ir=0, alu_out=0, instret=0, trap_out=0, mem_req=0; regs not reset.
//  FSM: FETCH(00) -> EXEC(01) -> [MEM(10)] -> FETCH; WB folded into EXEC/MEM completion.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc; on req&ready latch ir<=mem_rdata, go EXEC. Stall indefinitely while ready=0.
//  EXEC (1 cycle, mem_req=0): decode ir, read rs1/rs2, compute ALU/branch, latch alu_out.
//   ALU/LUI/AUIPC/JAL/JALR: write rd, pc<=next, instret++, -> FETCH.
//   Branch taken: pc<=pc+imm; not taken: pc+4. JAL: pc+imm; JALR: (rs1+imm)&~1; rd<=pc+4.
//   FENCE: nop, pc+4, retire. LOAD/STORE: alu_out=rs1+imm, -> MEM unless misaligned.
//  MEM: mem_req=1, mem_addr={alu_out[31:2],2'b00}; all request outputs held stable until ready.
//   Store: SB wstrb=0001<<a[1:0], wdata={4{rs2[7:0]}}; SH wstrb=0011<<a[1:0], wdata={2{rs2[15:0]}}; SW 1111.
//   Load: byte/half selected by a[1:0], sign- (LB/LH) or zero- (LBU/LHU) extended, written to rd at completion.
//   On completion pc<=pc+4, instret++, -> FETCH.
//  Traps (taken in EXEC, no register/memory side-effect, not retired): pc<=TRAP_PC, trap_out=1 for that cycle, -> FETCH.
//   Causes: ECALL/EBREAK; unknown opcode/funct3/funct7; rs1/rs2/rd index >= NREGS; LH/LHU/SH a[0]!=0;
//   LW/SW a[1:0]!=0; taken branch/JAL/JALR target with bit1 set.
//  x0 reads 0, writes discarded. Shift amount = low 5 bits. Arithmetic wraps modulo 2^32.
//  Write-back and pc update occur on same posedge; rd==rs1 sees old value within the instruction.
//  mem_ready while mem_req=0 ignored. Reset during MEM with ready=0: request dropped, no write, next req is fetch at RESET_PC.
//  CPI: ALU/branch 2 cycles, load/store 3 cycles, plus memory wait states.
// TESTING
//  Zero-wait mem, ADDI x1,x0,5; ADDI x2,x1,-7 -> x2=32'hFFFF_FFFE, instret=2 after 4 cycles, pc=8.
//  SW x2,0x100(x0) then LB x3,0x101(x0) with 3 wait states each -> wstrb=1111; x3=32'hFFFF_FFFF; LBU gives 0x000000FF.
//  SH x2,0x102(x0) -> mem_addr=0x100, wstrb=4'b1100, wdata=32'hFFFE_FFFE; LW from 0x102 -> trap_out pulse, pc=TRAP_PC, x unchanged.
//  BNE x1,x0,-8 at pc=0x10 with x1!=0 -> pc=0x08; JALR x5,x1,1 with x1=0x40 -> pc=0x40, x5=pc+4.
//  NREGS=16: ADDI x20,x0,1 -> trap, instret not incremented; ECALL -> pc=TRAP_PC=0x80.
//  Assert reset_n=0 mid-MEM store with ready held 0 -> no write strobe completes, pc=RESET_PC, state_out=00, instret=0.

Source files
------------

// File: rtl/rv32i_multicycle_if.sv
// Word-wide memory port of the multi-cycle RV32I core: one req/ready handshake shared by
// instruction fetch and data access.
interface rv32i_multicycle_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/rv32i_multicycle.sv
// Multi-cycle RV32I/RV32E core: FETCH -> EXEC -> [MEM] over a single waitable memory port,
// with precise traps on illegal/misaligned instructions and a retired-instruction counter.
module rv32i_multicycle #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0000,
   parameter int unsigned NREGS    = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   rv32i_multicycle_if.master mem,
   output logic [31:0]        pc_out,
   output logic [31:0]        op_out,
   output logic [31:0]        alu_out,
   output logic [1:0]         state_out,
   output logic               trap_out,
   output logic [31:0]        instret_out
);
   localparam int unsigned RW = $clog2(NREGS);
   localparam logic [1:0] FETCH = 2'b00, EXEC = 2'b01, MEM = 2'b10;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                          OP_FENCE = 7'b0001111;

   logic [1:0]  state;
   logic [31:0] pc, ir, alu_q, instret;
   logic        trap_q;
   logic [31:0] regs [NREGS];

   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'd0};
   assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign rs1_v  = (rs1 == 5'd0) ? 32'd0 : regs[rs1[RW-1:0]];
   assign rs2_v  = (rs2 == 5'd0) ? 32'd0 : regs[rs2[RW-1:0]];

   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         3'd0:    r = alt ? a - b : a + b;
         3'd1:    r = a << b[4:0];
         3'd2:    r = {31'd0, $signed(a) < $signed(b)};
         3'd3:    r = {31'd0, a < b};
         3'd4:    r = a ^ b;
         3'd5:    r = alt ? $signed(a) >>> b[4:0] : a >> b[4:0];
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   logic        illegal, misalign, use_rd, use_rs1, use_rs2, wr_en, go_mem, take, trap;
   logic [31:0] result, next_pc, ea;

   always_comb begin
      illegal  = 1'b0;
      misalign = 1'b0;
      use_rd   = 1'b0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      wr_en    = 1'b0;
      go_mem   = 1'b0;
      take     = 1'b0;
      result   = 32'd0;
      next_pc  = pc + 32'd4;
      ea       = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
      case (opcode)
         OP_IMM: begin
            {use_rd, use_rs1, wr_en} = 3'b111;
            result  = alu(funct3, (funct3 == 3'd5) & ir[30], rs1_v, imm_i);
            illegal = (funct3 == 3'd1 && funct7 != 7'h00) ||
                      (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
         end
         OP_REG: begin
            {use_rd, use_rs1, use_rs2, wr_en} = 4'b1111;
            result  = alu(funct3, ir[30], rs1_v, rs2_v);
            illegal = !(funct7 == 7'h00 ||
                        (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
         end
         OP_LUI:   begin {use_rd, wr_en} = 2'b11; result = imm_u; end
         OP_AUIPC: begin {use_rd, wr_en} = 2'b11; result = pc + imm_u; end
         OP_JAL: begin
            {use_rd, wr_en} = 2'b11;
            result   = pc + 32'd4;
            next_pc  = pc + imm_j;
            misalign = next_pc[1];
         end
         OP_JALR: begin
            {use_rd, use_rs1, wr_en} = 3'b111;
            result   = pc + 32'd4;
            next_pc  = (rs1_v + imm_i) & ~32'd1;
            misalign = next_pc[1];
            illegal  = (funct3 != 3'd0);
         end
         OP_BRANCH: begin
            {use_rs1, use_rs2} = 2'b11;
            result = pc + imm_b;
            case (funct3)
               3'd0:    take = (rs1_v == rs2_v);
               3'd1:    take = (rs1_v != rs2_v);
               3'd4:    take = ($signed(rs1_v) < $signed(rs2_v));
               3'd5:    take = ($signed(rs1_v) >= $signed(rs2_v));
               3'd6:    take = (rs1_v < rs2_v);
               3'd7:    take = (rs1_v >= rs2_v);
               default: illegal = 1'b1;
            endcase
            if (take) begin
               next_pc  = pc + imm_b;
               misalign = next_pc[1];
            end
         end
         OP_LOAD, OP_STORE: begin
            use_rs1 = 1'b1;
            use_rd  = (opcode == OP_LOAD);
            use_rs2 = (opcode == OP_STORE);
            go_mem  = 1'b1;
            result  = ea;
            illegal = (opcode == OP_LOAD) ? (funct3 == 3'd3 || funct3 > 3'd5) : (funct3 > 3'd2);
            misalign = (funct3[1:0] == 2'd1 && ea[0]) || (funct3[1:0] == 2'd2 && ea[1:0] != 2'd0);
         end
         OP_FENCE: ;
         default:  illegal = 1'b1;
      endcase
      trap = illegal | misalign | (use_rd && {27'd0, rd} >= NREGS) |
             (use_rs1 && {27'd0, rs1} >= NREGS) | (use_rs2 && {27'd0, rs2} >= NREGS);
   end

   // Lane steering uses the latched effective address; regs are untouched while in MEM.
   logic [31:0] ld_shift, ld_data, st_data;
   logic [3:0]  st_strb;
   always_comb begin
      ld_shift = mem.mem_rdata >> {alu_q[1:0], 3'b000};
      case (funct3)
         3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd4:    ld_data = {24'd0, ld_shift[7:0]};
         3'd5:    ld_data = {16'd0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
      case (funct3[1:0])
         2'd0:    begin st_strb = 4'b0001 << alu_q[1:0]; st_data = {4{rs2_v[7:0]}}; end
         2'd1:    begin st_strb = 4'b0011 << alu_q[1:0]; st_data = {2{rs2_v[15:0]}}; end
         default: begin st_strb = 4'b1111; st_data = rs2_v; end
      endcase
   end

   logic mem_done, rf_we;
   assign mem_done = (state == MEM) && mem.mem_req && mem.mem_ready;
   assign rf_we    = ((state == EXEC && !trap && wr_en) || (mem_done && opcode == OP_LOAD)) &&
                     (rd != 5'd0);

   always_ff @(posedge clock) begin
      if (rf_we) regs[rd[RW-1:0]] <= (state == MEM) ? ld_data : result;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         ir      <= 32'd0;
         alu_q   <= 32'd0;
         instret <= 32'd0;
         trap_q  <= 1'b0;
      end else begin
         trap_q <= 1'b0;
         case (state)
            FETCH: if (mem.mem_req && mem.mem_ready) begin
               ir    <= mem.mem_rdata;
               state <= EXEC;
            end
            EXEC: if (trap) begin
               pc     <= TRAP_PC;
               trap_q <= 1'b1;
               state  <= FETCH;
            end else begin
               alu_q <= result;
               if (go_mem) begin
                  state <= MEM;
               end else begin
                  pc      <= next_pc;
                  instret <= instret + 32'd1;
                  state   <= FETCH;
               end
            end
            MEM: if (mem_done) begin
               pc      <= pc + 32'd4;
               instret <= instret + 32'd1;
               state   <= FETCH;
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign mem.mem_req   = reset_n && (state == FETCH || state == MEM);
   assign mem.mem_we    = (state == MEM) && (opcode == OP_STORE);
   assign mem.mem_addr  = (state == MEM) ? {alu_q[31:2], 2'b00} : {pc[31:2], 2'b00};
   assign mem.mem_wstrb = mem.mem_we ? st_strb : 4'b0000;
   assign mem.mem_wdata = mem.mem_we ? st_data : 32'd0;

   assign pc_out      = pc;
   assign op_out      = ir;
   assign alu_out     = alu_q;
   assign state_out   = state;
   assign trap_out    = trap_q;
   assign instret_out = instret;
endmodule

// File: tb/tb_rv32i_multicycle.sv
// Directed bench for rv32i_multicycle (RV32E, TRAP_PC=0x80) against a wait-state memory model.
module tb_rv32i_multicycle;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] pc_out, op_out, alu_out, instret_out;
   logic [1:0]  state_out;
   logic        trap_out;
   int          tests = 0;
   int          fails = 0;

   rv32i_multicycle_if bus ();

   rv32i_multicycle #(.RESET_PC(32'h0), .TRAP_PC(32'h80), .NREGS(16)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .mem         (bus),
      .pc_out      (pc_out),
      .op_out      (op_out),
      .alu_out     (alu_out),
      .state_out   (state_out),
      .trap_out    (trap_out),
      .instret_out (instret_out)
   );

   always #5 clock = ~clock;

   // Memory model: 256 words, programmable wait states, hold forces ready low.
   logic [31:0] mem [256];
   int unsigned wait_n = 0, cnt = 0, writes = 0;
   logic        hold = 1'b0, clr = 1'b0, prog_we = 1'b0;
   logic [7:0]  prog_idx = 8'd0;
   logic [31:0] prog_word = 32'd0, last_addr = 32'd0, last_wdata = 32'd0;
   logic [3:0]  last_wstrb = 4'd0;

   assign bus.mem_ready = bus.mem_req && !hold && (cnt >= wait_n);
   assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

   always @(posedge clock) begin
      cnt <= (bus.mem_req && !bus.mem_ready) ? cnt + 1 : 0;
      if (clr) for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      if (prog_we) mem[prog_idx] <= prog_word;
      if (bus.mem_req && bus.mem_ready && bus.mem_we) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         writes     <= writes + 1;
         last_addr  <= bus.mem_addr;
         last_wstrb <= bus.mem_wstrb;
         last_wdata <= bus.mem_wdata;
      end
   end

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, JALR = 7'b1100111;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic poke(input logic [7:0] idx, input logic [31:0] w);
      prog_idx = idx; prog_word = w; prog_we = 1'b1;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic start_reset(input int unsigned waits);
      @(negedge clock);
      reset_n = 1'b0; hold = 1'b0; wait_n = waits; clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic wait_ret(input string tag, input logic [31:0] target);
      int n = 0;
      while (instret_out !== target && n < 400) begin tick(); n++; end
      check(tag, instret_out, target);
   endtask

   task automatic wait_trap(input string tag);
      int n = 0;
      while (trap_out !== 1'b1 && n < 400) begin tick(); n++; end
      check(tag, {31'd0, trap_out}, 32'd1);
   endtask

   initial begin
      int unsigned w0;
      int n;
      // Zero-wait ALU sequence, plus reset-state checks while reset_n is low.
      start_reset(0);
      poke(8'd0, enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI));
      poke(8'd1, enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, OPI));
      check("rst_pc", pc_out, 32'h0);
      check("rst_state", {30'd0, state_out}, 32'd0);
      check("rst_ir", op_out, 32'h0);
      check("rst_alu", alu_out, 32'h0);
      check("rst_instret", instret_out, 32'h0);
      check("rst_trap", {31'd0, trap_out}, 32'd0);
      check("rst_req", {31'd0, bus.mem_req}, 32'd0);
      release_reset();
      repeat (4) tick();
      check("alu_instret", instret_out, 32'd2);
      check("alu_pc", pc_out, 32'h8);
      check("alu_x2", alu_out, 32'hFFFF_FFFE);
      check("alu_ir", op_out, 32'hFF90_8113);

      // Loads/stores with 3 wait states, then a misaligned LW trap.
      start_reset(3);
      poke(8'd0, enc_i(12'h055, 5'd0, 3'd0, 5'd5, OPI));
      poke(8'd1, enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPI));
      poke(8'd2, enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, OPI));
      poke(8'd3, enc_s(12'h100, 5'd2, 5'd0, 3'd2));
      poke(8'd4, enc_i(12'h101, 5'd0, 3'd0, 5'd3, LD));
      poke(8'd5, enc_s(12'h104, 5'd3, 5'd0, 3'd2));
      poke(8'd6, enc_i(12'h101, 5'd0, 3'd4, 5'd4, LD));
      poke(8'd7, enc_s(12'h108, 5'd4, 5'd0, 3'd2));
      poke(8'd8, enc_s(12'h102, 5'd2, 5'd0, 3'd1));
      poke(8'd9, enc_i(12'h102, 5'd0, 3'd2, 5'd5, LD));
      poke(8'd32, enc_s(12'h10C, 5'd5, 5'd0, 3'd2));
      poke(8'd33, enc_j(21'd0, 5'd0));
      release_reset();
      wait_ret("sw_ret", 32'd4);
      check("sw_word", mem[64], 32'hFFFF_FFFE);
      check("sw_strb", {28'd0, last_wstrb}, 32'hF);
      check("sw_addr", last_addr, 32'h100);
      wait_ret("lb_ret", 32'd6);
      check("lb_x3", mem[65], 32'hFFFF_FFFF);
      wait_ret("lbu_ret", 32'd8);
      check("lbu_x4", mem[66], 32'h0000_00FF);
      wait_ret("sh_ret", 32'd9);
      check("sh_addr", last_addr, 32'h100);
      check("sh_strb", {28'd0, last_wstrb}, 32'hC);
      check("sh_wdata", last_wdata, 32'hFFFE_FFFE);
      check("sh_word", mem[64], 32'hFFFE_FFFE);
      wait_trap("lw_trap");
      check("lw_trap_pc", pc_out, 32'h80);
      check("lw_trap_instret", instret_out, 32'd9);
      wait_ret("x5_ret", 32'd10);
      check("x5_unchanged", mem[67], 32'h0000_0055);

      // Branch and JALR redirects.
      start_reset(0);
      poke(8'd0, enc_i(12'h040, 5'd0, 3'd0, 5'd1, OPI));
      poke(8'd1, enc_j(21'd12, 5'd0));
      poke(8'd2, enc_i(12'd1, 5'd1, 3'd0, 5'd5, JALR));
      poke(8'd3, enc_i(12'd0, 5'd0, 3'd0, 5'd0, OPI));
      poke(8'd4, enc_b(13'h1FF8, 5'd0, 5'd1, 3'd1));
      poke(8'd16, enc_s(12'h110, 5'd5, 5'd0, 3'd2));
      poke(8'd17, enc_j(21'd0, 5'd0));
      release_reset();
      wait_ret("bne_ret", 32'd3);
      check("bne_pc", pc_out, 32'h08);
      wait_ret("jalr_ret", 32'd4);
      check("jalr_pc", pc_out, 32'h40);
      check("jalr_link", alu_out, 32'h0C);
      wait_ret("x5_link_ret", 32'd5);
      check("x5_link", mem[68], 32'h0C);

      // RV32E register bound and ECALL traps.
      start_reset(0);
      poke(8'd0, enc_i(12'd1, 5'd0, 3'd0, 5'd20, OPI));
      poke(8'd32, enc_i(12'd1, 5'd0, 3'd0, 5'd1, OPI));
      poke(8'd33, 32'h0000_0073);
      release_reset();
      wait_trap("x20_trap");
      check("x20_pc", pc_out, 32'h80);
      check("x20_instret", instret_out, 32'd0);
      tick();
      check("trap_pulse_end", {31'd0, trap_out}, 32'd0);
      wait_ret("pre_ecall_ret", 32'd1);
      wait_trap("ecall_trap");
      check("ecall_pc", pc_out, 32'h80);
      check("ecall_instret", instret_out, 32'd1);

      // Reset while a store sits in MEM with ready held low.
      start_reset(0);
      poke(8'd0, enc_i(12'd3, 5'd0, 3'd0, 5'd1, OPI));
      poke(8'd1, enc_s(12'h100, 5'd1, 5'd0, 3'd2));
      release_reset();
      wait_ret("pre_store_ret", 32'd1);
      n = 0;
      while (state_out !== 2'b10 && n < 50) begin tick(); n++; end
      hold = 1'b1;
      w0 = writes;
      check("mem_state", {30'd0, state_out}, 32'd2);
      repeat (3) tick();
      check("mem_held_addr", bus.mem_addr, 32'h100);
      check("mem_held_strb", {28'd0, bus.mem_wstrb}, 32'hF);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("mr_pc", pc_out, 32'h0);
      check("mr_state", {30'd0, state_out}, 32'd0);
      check("mr_instret", instret_out, 32'd0);
      check("mr_req", {31'd0, bus.mem_req}, 32'd0);
      tick();
      check("mr_no_write", writes, w0);
      check("mr_mem", mem[64], 32'h0);
      hold = 1'b0;
      release_reset();
      tick();
      check("mr_refetch", op_out, enc_i(12'd3, 5'd0, 3'd0, 5'd1, OPI));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
